// File: rtl/vscale_hasti_dp_sram.sv
//------------------------------------------------------------------------------
// vscale_hasti_dp_sram
//   Unified dual-port HASTI (AHB-Lite) SRAM. Port 0 serves instruction fetch,
//   port 1 serves data; both share one backing array so self-modifying code
//   and data-in-code work without copying.
//   Optional feature macro: VSCALE_DP_SRAM_COLLISION_CNT_EN adds a saturating
//   16-bit counter of same-word write/write collisions.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

// Per-port AHB-Lite slave control: address-phase capture, wait states and
// the two-cycle ERROR response. The array itself lives in the top level.
module vscale_hasti_dp_sram_port #(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned MEM_WORDS   = 2**ADDR_WIDTH,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [1:0]            htrans,
  output logic                  hready,
  output logic                  hresp,
  output logic                  dp_done,
  output logic                  dp_write,
  output logic [ADDR_WIDTH-1:0] dp_idx,
  output logic [3:0]            dp_be
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;
  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_STATES);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  dp_valid_q, dp_valid_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;

  logic                  accept;
  logic                  req_illegal;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  unused_bits;

  // Address bits above the populated window and the SEQ/NONSEQ distinction
  // carry no meaning for a single-transfer slave.
  assign unused_bits = ^{haddr[31:ADDR_WIDTH+2], htrans[0]};

  assign req_idx = haddr[ADDR_WIDTH+1:2];
  assign accept  = hready & htrans[1];

  // Classify the transfer presented in the address phase.
  always_comb begin
    req_illegal = 1'b0;
    if (hsize > HSIZE_WORD)
      req_illegal = 1'b1;
    if ((hsize == HSIZE_HALF) && haddr[0])
      req_illegal = 1'b1;
    if ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00))
      req_illegal = 1'b1;
    if (32'(req_idx) >= MEM_WORDS)
      req_illegal = 1'b1;
  end

  // Bus handshake outputs are pure functions of the FSM state and counter.
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    case (state_q)
      ST_WAIT: hready = (cnt_q == 4'd0);
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

  // Next state: stall while hready is low, otherwise retire the current data
  // phase and optionally accept a new address phase in the same cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dp_valid_d = dp_valid_q;
    write_d    = write_q;
    size_d     = size_q;
    addr_d     = addr_q;
    if (!hready) begin
      if (state_q == ST_ERR1)
        state_d = ST_ERR2;
      else
        cnt_d = cnt_q - 4'd1;
    end else begin
      state_d    = ST_IDLE;
      dp_valid_d = 1'b0;
      if (accept) begin
        if (req_illegal) begin
          state_d = ST_ERR1;
        end else begin
          dp_valid_d = 1'b1;
          write_d    = hwrite;
          size_d     = hsize[1:0];
          addr_d     = haddr[ADDR_WIDTH+1:0];
          if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
    end
  end

  // State and pipeline registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      dp_valid_q <= 1'b0;
      write_q    <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dp_valid_q <= dp_valid_d;
      write_q    <= write_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
    end
  end

  assign dp_done  = dp_valid_q & hready;
  assign dp_write = write_q;
  assign dp_idx   = addr_q[ADDR_WIDTH+1:2];

  // Byte-lane enables from the registered size and low address bits.
  always_comb begin
    dp_be = 4'b1111;
    case (size_q)
      2'd0:    dp_be = 4'b0001 << addr_q[1:0];
      2'd1:    dp_be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: dp_be = 4'b1111;
    endcase
  end

endmodule

module vscale_hasti_dp_sram #(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned MEM_WORDS   = 2**ADDR_WIDTH,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
`ifdef VSCALE_DP_SRAM_COLLISION_CNT_EN
  output logic [15:0] collision_cnt,
`endif
  input  logic [31:0] p0_haddr,
  input  logic        p0_hwrite,
  input  logic [2:0]  p0_hsize,
  input  logic [2:0]  p0_hburst,
  input  logic        p0_hmastlock,
  input  logic [3:0]  p0_hprot,
  input  logic [1:0]  p0_htrans,
  input  logic [31:0] p0_hwdata,
  output logic [31:0] p0_hrdata,
  output logic        p0_hready,
  output logic        p0_hresp,
  input  logic [31:0] p1_haddr,
  input  logic        p1_hwrite,
  input  logic [2:0]  p1_hsize,
  input  logic [2:0]  p1_hburst,
  input  logic        p1_hmastlock,
  input  logic [3:0]  p1_hprot,
  input  logic [1:0]  p1_htrans,
  input  logic [31:0] p1_hwdata,
  output logic [31:0] p1_hrdata,
  output logic        p1_hready,
  output logic        p1_hresp
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  logic                  p0_done, p1_done;
  logic                  p0_write, p1_write;
  logic [ADDR_WIDTH-1:0] p0_idx, p1_idx;
  logic [3:0]            p0_be, p1_be;
  logic                  p0_we, p1_we;
  logic                  unused_ctrl;

  // Burst, lock and protection attributes do not affect a plain SRAM.
  assign unused_ctrl = ^{p0_hburst, p0_hmastlock, p0_hprot,
                         p1_hburst, p1_hmastlock, p1_hprot};

  vscale_hasti_dp_sram_port #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .MEM_WORDS   (MEM_WORDS),
    .WAIT_STATES (WAIT_STATES)
  ) u_port0 (
    .clk      (hclk),
    .rst_n    (hresetn),
    .haddr    (p0_haddr),
    .hwrite   (p0_hwrite),
    .hsize    (p0_hsize),
    .htrans   (p0_htrans),
    .hready   (p0_hready),
    .hresp    (p0_hresp),
    .dp_done  (p0_done),
    .dp_write (p0_write),
    .dp_idx   (p0_idx),
    .dp_be    (p0_be)
  );

  vscale_hasti_dp_sram_port #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .MEM_WORDS   (MEM_WORDS),
    .WAIT_STATES (WAIT_STATES)
  ) u_port1 (
    .clk      (hclk),
    .rst_n    (hresetn),
    .haddr    (p1_haddr),
    .hwrite   (p1_hwrite),
    .hsize    (p1_hsize),
    .htrans   (p1_htrans),
    .hready   (p1_hready),
    .hresp    (p1_hresp),
    .dp_done  (p1_done),
    .dp_write (p1_write),
    .dp_idx   (p1_idx),
    .dp_be    (p1_be)
  );

  assign p0_we = p0_done & p0_write;
  assign p1_we = p1_done & p1_write;

  // Array write on the edge closing each data phase. Port 1 lanes are
  // assigned first so port 0 wins any lane both ports enable.
  always_ff @(posedge hclk) begin
    for (int b = 0; b < 4; b++) begin
      if (p1_we && p1_be[b])
        mem[p1_idx][8*b +: 8] <= p1_hwdata[8*b +: 8];
      if (p0_we && p0_be[b])
        mem[p0_idx][8*b +: 8] <= p0_hwdata[8*b +: 8];
    end
  end

  // Combinational read of the whole word in the completing cycle; a write
  // landing on the same edge is not yet visible, so reads see old data.
  always_comb begin
    p0_hrdata = 32'd0;
    p1_hrdata = 32'd0;
    if (p0_done && !p0_write)
      p0_hrdata = mem[p0_idx];
    if (p1_done && !p1_write)
      p1_hrdata = mem[p1_idx];
  end

`ifdef VSCALE_DP_SRAM_COLLISION_CNT_EN
  logic [15:0] collision_cnt_q, collision_cnt_d;

  // Saturating count of cycles where both ports finish writing one word.
  always_comb begin
    collision_cnt_d = collision_cnt_q;
    if (p0_we && p1_we && (p0_idx == p1_idx) && (collision_cnt_q != 16'hFFFF))
      collision_cnt_d = collision_cnt_q + 16'd1;
  end

  // Collision counter register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)
      collision_cnt_q <= 16'd0;
    else
      collision_cnt_q <= collision_cnt_d;
  end

  assign collision_cnt = collision_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vscale_hasti_dp_sram.sv
//------------------------------------------------------------------------------
// tb_vscale_hasti_dp_sram
//   Self-checking bench for vscale_hasti_dp_sram. Two instances: one with no
//   wait states and a reduced MEM_WORDS, one with three wait states.
//   Port index: 0 = dut0.p0, 1 = dut0.p1, 2 = dut3.p0, 3 = dut3.p1.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vscale_hasti_dp_sram;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [2:0] SZ_B     = 3'd0;
  localparam logic [2:0] SZ_H     = 3'd1;
  localparam logic [2:0] SZ_W     = 3'd2;

  logic clk;
  logic hresetn;

  logic [3:0][31:0] haddr;
  logic [3:0]       hwrite;
  logic [3:0][2:0]  hsize;
  logic [3:0][1:0]  htrans;
  logic [3:0][31:0] hwdata;
  logic [3:0][31:0] hrdata;
  logic [3:0]       hready;
  logic [3:0]       hresp;

  logic [3:0]  rd_flag;
  logic [3:0]  pend;
  logic [31:0] exp_q [4][$];

  int vectors;
  int miscompares;

`ifdef VSCALE_DP_SRAM_COLLISION_CNT_EN
  logic [15:0] coll0, coll3;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vscale_hasti_dp_sram #(.ADDR_WIDTH(14), .MEM_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .hclk(clk), .hresetn(hresetn),
`ifdef VSCALE_DP_SRAM_COLLISION_CNT_EN
    .collision_cnt(coll0),
`endif
    .p0_haddr(haddr[0]), .p0_hwrite(hwrite[0]), .p0_hsize(hsize[0]),
    .p0_hburst(3'b000), .p0_hmastlock(1'b0), .p0_hprot(4'b0011),
    .p0_htrans(htrans[0]), .p0_hwdata(hwdata[0]),
    .p0_hrdata(hrdata[0]), .p0_hready(hready[0]), .p0_hresp(hresp[0]),
    .p1_haddr(haddr[1]), .p1_hwrite(hwrite[1]), .p1_hsize(hsize[1]),
    .p1_hburst(3'b000), .p1_hmastlock(1'b0), .p1_hprot(4'b0011),
    .p1_htrans(htrans[1]), .p1_hwdata(hwdata[1]),
    .p1_hrdata(hrdata[1]), .p1_hready(hready[1]), .p1_hresp(hresp[1])
  );

  vscale_hasti_dp_sram #(.ADDR_WIDTH(14), .WAIT_STATES(3)) u_dut3 (
    .hclk(clk), .hresetn(hresetn),
`ifdef VSCALE_DP_SRAM_COLLISION_CNT_EN
    .collision_cnt(coll3),
`endif
    .p0_haddr(haddr[2]), .p0_hwrite(hwrite[2]), .p0_hsize(hsize[2]),
    .p0_hburst(3'b000), .p0_hmastlock(1'b0), .p0_hprot(4'b0011),
    .p0_htrans(htrans[2]), .p0_hwdata(hwdata[2]),
    .p0_hrdata(hrdata[2]), .p0_hready(hready[2]), .p0_hresp(hresp[2]),
    .p1_haddr(haddr[3]), .p1_hwrite(hwrite[3]), .p1_hsize(hsize[3]),
    .p1_hburst(3'b000), .p1_hmastlock(1'b0), .p1_hprot(4'b0011),
    .p1_htrans(htrans[3]), .p1_hwdata(hwdata[3]),
    .p1_hrdata(hrdata[3]), .p1_hready(hready[3]), .p1_hresp(hresp[3])
  );

  // Scoreboard consumer: a read data phase completes when hready is high
  // after an accepted read address phase; pop and compare there.
  initial begin
    pend = 4'b0000;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!hresetn) begin
          pend[i] = 1'b0;
        end else begin
          if (pend[i] && hready[i]) begin
            vectors++;
            if (exp_q[i].size() == 0) begin
              miscompares++;
              $display("FAIL rd_data port%0d: got %h with no expected entry, want none", i, hrdata[i]);
            end else begin
              logic [31:0] e;
              e = exp_q[i].pop_front();
              if (hrdata[i] !== e || hresp[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL rd_data port%0d: got %h resp %b, want %h resp 0", i, hrdata[i], hresp[i], e);
              end
            end
            pend[i] = 1'b0;
          end
          if (hready[i] && rd_flag[i])
            pend[i] = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [31:0] a);
    htrans[i]  = tr;
    hwrite[i]  = wr;
    hsize[i]   = sz;
    haddr[i]   = a;
    rd_flag[i] = 1'b0;
  endtask

  task automatic drive_rd(input int i, input logic [31:0] a, input logic [31:0] e);
    drive(i, T_NONSEQ, 1'b0, SZ_W, a);
    rd_flag[i] = 1'b1;
    exp_q[i].push_back(e);
  endtask

  task automatic idle(input int i);
    drive(i, T_IDLE, 1'b0, SZ_W, 32'd0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (hready[i] !== 1'b1 || hresp[i] !== 1'b0 || hrdata[i] !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_out port%0d: got rdy %b resp %b rdata %h, want 1 0 00000000",
                 i, hready[i], hresp[i], hrdata[i]);
      end
    end
`ifdef VSCALE_DP_SRAM_COLLISION_CNT_EN
    vectors++;
    if (coll0 !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_coll: got %0d, want 0", coll0);
    end
`endif
    tick();
    hresetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (hready[0] !== 1'b1 || hresp[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_ready cyc%0d: got rdy %b resp %b, want 1 0", k, hready[0], hresp[0]);
      end
      tick();
    end
  endtask

  task automatic test_wait0_basic();
    drive(1, T_NONSEQ, 1'b1, SZ_W, 32'h100);
    tick();
    hwdata[1] = 32'hDEADBEEF;
    idle(1);
    drive_rd(0, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    vectors++;
    if (hready[1] !== 1'b1 || hresp[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL w0_wr_done: got rdy %b resp %b, want 1 0", hready[1], hresp[1]);
    end
    tick();
    idle(0);
    @(negedge clk);
    tick();
  endtask

  task automatic test_lanes();
    drive(1, T_NONSEQ, 1'b1, SZ_W, 32'h40);
    tick();
    hwdata[1] = 32'h00000000;
    drive(1, T_NONSEQ, 1'b1, SZ_B, 32'h41);
    tick();
    hwdata[1] = 32'hAAAAAAAA;
    drive(1, T_NONSEQ, 1'b1, SZ_H, 32'h42);
    tick();
    hwdata[1] = 32'h12341234;
    drive_rd(1, 32'h40, 32'h1234AA00);
    @(negedge clk);
    vectors++;
    if (hready[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL lanes_ready: got %b, want 1", hready[1]);
    end
    tick();
    idle(1);
    @(negedge clk);
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      if (k > 0 && k <= 4)
        hwdata[1] = 32'hA5000000 + 32'(k - 1);
      if (k < 4)
        drive(1, T_NONSEQ, 1'b1, SZ_W, 32'h200 + 32'(4 * k));
      else
        drive_rd(1, 32'h200 + 32'(4 * (k - 4)), 32'hA5000000 + 32'(k - 4));
      @(negedge clk);
      vectors++;
      if (hready[1] !== 1'b1 || hresp[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_ready cyc%0d: got rdy %b resp %b, want 1 0", k, hready[1], hresp[1]);
      end
      tick();
    end
    idle(1);
    @(negedge clk);
    tick();
  endtask

  task automatic test_errors();
    logic [31:0] bad_addr [3];
    logic [2:0]  bad_size [3];
    logic        bad_wr   [3];
    bad_addr[0] = 32'h102;  bad_size[0] = SZ_W; bad_wr[0] = 1'b1;
    bad_addr[1] = 32'h1000; bad_size[1] = SZ_W; bad_wr[1] = 1'b1;
    bad_addr[2] = 32'h0;    bad_size[2] = 3'd3; bad_wr[2] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      drive(1, T_NONSEQ, bad_wr[n], bad_size[n], bad_addr[n]);
      tick();
      hwdata[1] = 32'hFFFFFFFF;
      idle(1);
      @(negedge clk);
      vectors++;
      if (hready[1] !== 1'b0 || hresp[1] !== 1'b1 || hrdata[1] !== 32'd0) begin
        miscompares++;
        $display("FAIL err1 case%0d: got rdy %b resp %b rdata %h, want 0 1 00000000",
                 n, hready[1], hresp[1], hrdata[1]);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (hready[1] !== 1'b1 || hresp[1] !== 1'b1) begin
        miscompares++;
        $display("FAIL err2 case%0d: got rdy %b resp %b, want 1 1", n, hready[1], hresp[1]);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (hready[1] !== 1'b1 || hresp[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL err_end case%0d: got rdy %b resp %b, want 1 0", n, hready[1], hresp[1]);
      end
      tick();
    end
    // The misaligned write targeted the word at 0x100; it must be intact.
    drive_rd(1, 32'h100, 32'hDEADBEEF);
    tick();
    // Last legal word index (MEM_WORDS-1) accepts a write and reads back.
    drive(1, T_NONSEQ, 1'b1, SZ_W, 32'hFFC);
    tick();
    hwdata[1] = 32'h600DCAFE;
    drive_rd(1, 32'hFFC, 32'h600DCAFE);
    @(negedge clk);
    vectors++;
    if (hresp[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL last_word_resp: got %b, want 0", hresp[1]);
    end
    tick();
    idle(1);
    @(negedge clk);
    tick();
  endtask

  task automatic test_wait3();
    bit done;
    drive(3, T_NONSEQ, 1'b1, SZ_W, 32'h300);
    tick();
    hwdata[3] = 32'hCAFEF00D;
    idle(3);
    done = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (hready[3]) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL ws3_preload: got no hready in 10 cycles, want completion");
    end
    tick();
    drive_rd(2, 32'h300, 32'hCAFEF00D);
    tick();
    for (int k = 1; k <= 5; k++) begin
      if (k == 1) begin
        idle(2);
        drive(3, T_NONSEQ, 1'b1, SZ_W, 32'h304);
      end
      if (k == 2) begin
        hwdata[3] = 32'h0BEEF304;
        idle(3);
      end
      @(negedge clk);
      if (k <= 4) begin
        vectors++;
        if (hready[2] !== (k == 4)) begin
          miscompares++;
          $display("FAIL ws3_p0_ready cyc%0d: got %b, want %b", k, hready[2], (k == 4));
        end
      end
      if (k >= 2) begin
        vectors++;
        if (hready[3] !== (k == 5)) begin
          miscompares++;
          $display("FAIL ws3_p1_ready cyc%0d: got %b, want %b", k, hready[3], (k == 5));
        end
      end
      tick();
    end
    drive_rd(3, 32'h304, 32'h0BEEF304);
    tick();
    idle(3);
    done = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (hready[3]) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL ws3_readback: got no hready in 10 cycles, want completion");
    end
    tick();
  endtask

  task automatic test_collision();
    drive(0, T_NONSEQ, 1'b1, SZ_W, 32'h80);
    drive(1, T_NONSEQ, 1'b1, SZ_W, 32'h80);
    tick();
    hwdata[0] = 32'h11111111;
    hwdata[1] = 32'h22222222;
    drive(0, T_NONSEQ, 1'b1, SZ_B, 32'h84);
    drive(1, T_NONSEQ, 1'b1, SZ_W, 32'h84);
    tick();
    hwdata[0] = 32'h33333333;
    hwdata[1] = 32'h44444444;
    drive_rd(0, 32'h80, 32'h11111111);
    drive(1, T_NONSEQ, 1'b1, SZ_W, 32'h80);
`ifdef VSCALE_DP_SRAM_COLLISION_CNT_EN
    @(negedge clk);
    vectors++;
    if (coll0 !== 16'd1) begin
      miscompares++;
      $display("FAIL coll_cnt_1: got %0d, want 1", coll0);
    end
`endif
    tick();
    hwdata[1] = 32'h55555555;
    drive_rd(0, 32'h84, 32'h44444433);
    idle(1);
`ifdef VSCALE_DP_SRAM_COLLISION_CNT_EN
    @(negedge clk);
    vectors++;
    if (coll0 !== 16'd2) begin
      miscompares++;
      $display("FAIL coll_cnt_2: got %0d, want 2", coll0);
    end
`endif
    tick();
    idle(0);
    drive_rd(1, 32'h80, 32'h55555555);
    tick();
    idle(1);
    @(negedge clk);
`ifdef VSCALE_DP_SRAM_COLLISION_CNT_EN
    vectors++;
    if (coll0 !== 16'd2) begin
      miscompares++;
      $display("FAIL coll_cnt_rw: got %0d, want 2", coll0);
    end
`endif
    tick();
  endtask

  task automatic test_reset_abort();
    drive(1, T_NONSEQ, 1'b1, SZ_W, 32'h500);
    tick();
    hwdata[1] = 32'h0BADF00D;
    idle(1);
    @(negedge clk);
    tick();
    drive(1, T_NONSEQ, 1'b1, SZ_W, 32'h500);
    tick();
    hwdata[1] = 32'h12345678;
    idle(1);
    #1;
    hresetn = 1'b0;
    #1;
    vectors++;
    if (hready[1] !== 1'b1 || hresp[1] !== 1'b0 || hrdata[1] !== 32'd0) begin
      miscompares++;
      $display("FAIL abort_out: got rdy %b resp %b rdata %h, want 1 0 00000000",
               hready[1], hresp[1], hrdata[1]);
    end
    tick();
    hresetn = 1'b1;
    tick();
    drive_rd(1, 32'h500, 32'h0BADF00D);
    tick();
    idle(1);
    @(negedge clk);
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    hresetn     = 1'b0;
    haddr       = '0;
    hwrite      = '0;
    hsize       = '0;
    htrans      = '0;
    hwdata      = '0;
    rd_flag     = '0;

    test_reset();
    test_wait0_basic();
    test_lanes();
    test_back_to_back();
    test_errors();
    test_wait3();
    test_collision();
    test_reset_abort();

    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (exp_q[i].size() != 0) begin
        miscompares++;
        $display("FAIL sb_drain port%0d: got %0d outstanding reads, want 0", i, exp_q[i].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
